// File: rtl/cfg_loader_pkg.sv
// ----------------------------------------------------------------------------
// cfg_loader_pkg
//   Shared definitions for the configuration chain loader: the loader FSM
//   state encoding, the default geometry of the target chain, and helper
//   functions that derive counter widths and word counts from that geometry.
//   NUM_WORDS / CNT_W describe the default 32-bit x 96-bit chain. Modules that
//   are parameterised differently call the helpers with their own values.
// ----------------------------------------------------------------------------
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHAIN_RST,
    FETCH,
    SHIFT,
    DONE
  } state_e;

  localparam int unsigned DEF_WORD_W    = 32;
  localparam int unsigned DEF_CHAIN_LEN = 96;

  // Number of host words needed to cover chain_len bits.
  function automatic int unsigned num_words(input int unsigned chain_len,
                                            input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned NUM_WORDS = num_words(DEF_CHAIN_LEN, DEF_WORD_W);
  localparam int unsigned CNT_W     = cnt_width(DEF_CHAIN_LEN);

endpackage

// File: rtl/config_chain_loader.sv
// ----------------------------------------------------------------------------
// config_chain_loader
//   Loads a serial configuration chain from a host word stream. A load first
//   resets every chain cell for RST_CYCLES cycles. It then fetches words and
//   shifts them into the chain LSB first. Exactly CHAIN_LEN shifts are issued
//   per load. Any surplus high bits of the final word are dropped. On the last
//   shift the chain tail must still read 0, because the first bit written has
//   not reached it yet. A nonzero tail sets the sticky echo_err flag.
//
// Ports
//   clk, reset     : clock, asynchronous active-high reset
//   start          : one-cycle load request, honoured only when idle
//   busy, done     : load in progress / one-cycle completion pulse
//   word_valid/ready/data : host word handshake, bit 0 shifted first
//   config_reset   : reset to all chain cells
//   config_in      : serial data into the chain head
//   config_shift   : one chain shift per asserted cycle
//   config_out     : chain tail, used for the echo check
//   echo_err       : sticky echo-check failure, cleared by the next start
// ----------------------------------------------------------------------------
module config_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned WORD_W     = DEF_WORD_W,
  parameter int unsigned CHAIN_LEN  = DEF_CHAIN_LEN,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [WORD_W-1:0] word_data,
  output logic              config_reset,
  output logic              config_in,
  output logic              config_shift,
  input  logic              config_out,
  output logic              echo_err
);

  localparam int unsigned BIT_CNT_W = cnt_width(CHAIN_LEN);
  localparam int unsigned WRD_CNT_W = cnt_width(WORD_W - 1);
  localparam int unsigned RST_CNT_W = cnt_width(RST_CYCLES - 1);

  localparam logic [BIT_CNT_W-1:0] LAST_CHAIN_BIT = BIT_CNT_W'(CHAIN_LEN - 1);
  localparam logic [WRD_CNT_W-1:0] LAST_WORD_BIT  = WRD_CNT_W'(WORD_W - 1);
  localparam logic [RST_CNT_W-1:0] LAST_RST_CYCLE = RST_CNT_W'(RST_CYCLES - 1);

  state_e               state_q;
  logic [WORD_W-1:0]    shreg_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;   // index of the chain bit on config_in
  logic [WRD_CNT_W-1:0] wrd_cnt_q;   // index of that bit within its word
  logic [RST_CNT_W-1:0] rst_cnt_q;

  logic busy_q;
  logic done_q;
  logic word_ready_q;
  logic config_reset_q;
  logic config_in_q;
  logic config_shift_q;
  logic echo_err_q;

  logic last_in_chain;
  logic last_in_word;

  assign last_in_chain = (bit_cnt_q == LAST_CHAIN_BIT);
  assign last_in_word  = (wrd_cnt_q == LAST_WORD_BIT);

  // Each output register is loaded on the edge that enters a state. It holds
  // the value for that state, so outputs never glitch and each one matches
  // the state it belongs to.
  // NOTE: every register in this block uses non-blocking assignment, so all
  // next-state terms read pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
      wrd_cnt_q      <= '0;
      rst_cnt_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      word_ready_q   <= 1'b0;
      // Chain cells are held in reset until the first edge after release.
      config_reset_q <= 1'b1;
      config_in_q    <= 1'b0;
      config_shift_q <= 1'b0;
      echo_err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          config_reset_q <= 1'b0;
          if (start) begin
            state_q        <= CHAIN_RST;
            busy_q         <= 1'b1;
            config_reset_q <= 1'b1;
            echo_err_q     <= 1'b0;
            bit_cnt_q      <= '0;
            rst_cnt_q      <= '0;
          end
        end

        CHAIN_RST: begin
          if (rst_cnt_q == LAST_RST_CYCLE) begin
            state_q        <= FETCH;
            config_reset_q <= 1'b0;
            word_ready_q   <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end

        FETCH: begin
          // word_ready is high throughout FETCH, so valid alone completes
          // the handshake. Bit 0 goes straight to config_in.
          if (word_valid) begin
            state_q        <= SHIFT;
            word_ready_q   <= 1'b0;
            config_shift_q <= 1'b1;
            config_in_q    <= word_data[0];
            shreg_q        <= word_data >> 1;
            wrd_cnt_q      <= '0;
          end
        end

        SHIFT: begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          // The tail still shows the reset value on the final shift.
          if (last_in_chain && config_out) begin
            echo_err_q <= 1'b1;
          end
          if (last_in_chain) begin
            // Any bits still in shreg_q belong past the chain end and are dropped.
            state_q        <= DONE;
            config_shift_q <= 1'b0;
            config_in_q    <= 1'b0;
            done_q         <= 1'b1;
          end else if (last_in_word) begin
            state_q        <= FETCH;
            config_shift_q <= 1'b0;
            config_in_q    <= 1'b0;
            word_ready_q   <= 1'b1;
          end else begin
            config_in_q <= shreg_q[0];
            shreg_q     <= shreg_q >> 1;
            wrd_cnt_q   <= wrd_cnt_q + 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign word_ready   = word_ready_q;
  assign config_reset = config_reset_q;
  assign config_in    = config_in_q;
  assign config_shift = config_shift_q;
  assign echo_err     = echo_err_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// ----------------------------------------------------------------------------
// tb_config_chain_loader
//   Two loaders share one clock, reset and host word bus. One targets a
//   96-bit chain and the other a 40-bit chain. The 96-bit loader is compared
//   every cycle against a behavioural model that tracks the load phase as
//   counters plus a queue of pending chain bits. A 96-cell chain model is
//   attached to it. The 40-bit loader is checked with literal expectations.
// ----------------------------------------------------------------------------
module tb_config_chain_loader;

  localparam int WORD_W     = 32;
  localparam int CHAIN_LEN  = 96;
  localparam int RST_CYCLES = 4;
  localparam int CHAIN_B    = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = '0;

  logic busy, done, word_ready, config_reset, config_in, config_shift, echo_err;
  logic config_out;
  logic busy_b, done_b, word_ready_b, config_reset_b, config_in_b, config_shift_b, echo_err_b;
  logic config_out_b = 1'b0;

  always #5 clk = ~clk;

  config_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy), .done(done),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .config_reset(config_reset), .config_in(config_in), .config_shift(config_shift),
    .config_out(config_out), .echo_err(echo_err)
  );

  config_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_B), .RST_CYCLES(RST_CYCLES)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .word_valid(word_valid), .word_ready(word_ready_b), .word_data(word_data),
    .config_reset(config_reset_b), .config_in(config_in_b), .config_shift(config_shift_b),
    .config_out(config_out_b), .echo_err(echo_err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of the physical chain: cells cleared by config_reset, shifting head->tail.
  logic [CHAIN_LEN-1:0] chain_q = '0;
  bit force_one = 1'b0;   // stuck-at-1 tail fault
  always @(posedge clk) begin
    if (config_reset)      chain_q <= '0;
    else if (config_shift) chain_q <= {chain_q[CHAIN_LEN-2:0], config_in};
  end
  assign config_out = force_one | chain_q[CHAIN_LEN-1];

  // Behavioural reference for the 96-bit loader.
  bit m_busy = 0, m_fetch = 0, m_done = 0, m_err = 0, m_post_rst = 0;
  int m_rst_left = 0, m_shifted = 0;
  bit m_pend[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_fetch = 0; m_done = 0; m_err = 0; m_post_rst = 1;
      m_rst_left = 0; m_shifted = 0; m_pend.delete();
    end else begin
      m_post_rst = 0;
      if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (!m_busy) begin
        if (start_a) begin
          m_busy = 1; m_rst_left = RST_CYCLES; m_err = 0; m_shifted = 0;
        end
      end else if (m_rst_left > 0) begin
        m_rst_left--;
        m_fetch = (m_rst_left == 0);
      end else if (m_fetch) begin
        if (word_valid) begin
          m_fetch = 0;
          for (int i = 0; i < WORD_W && m_shifted + i < CHAIN_LEN; i++) m_pend.push_back(word_data[i]);
        end
      end else if (m_pend.size() > 0) begin
        if (m_shifted == CHAIN_LEN - 1 && config_out) m_err = 1;
        void'(m_pend.pop_front());
        m_shifted++;
        if (m_pend.size() == 0) begin
          if (m_shifted == CHAIN_LEN) m_done = 1;
          else                        m_fetch = 1;
        end
      end
    end
  end

  bit checking = 0;
  always @(negedge clk) begin
    if (checking) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("word_ready", word_ready, m_fetch);
      check("config_shift", config_shift, m_pend.size() > 0);
      check("config_reset", config_reset, m_post_rst || m_rst_left > 0);
      check("echo_err", echo_err, m_err);
      if (m_pend.size() > 0) check("config_in", config_in, m_pend[0]);
    end
  end

  // Activity logs for the literal expectations.
  int shift_cnt = 0, done_cnt = 0, starve_cnt = 0;
  int shift_cnt_b = 0, done_cnt_b = 0;
  bit bits_a[256];
  bit bits_b[64];
  always @(negedge clk) begin
    if (config_shift) begin
      if (shift_cnt < 256) bits_a[shift_cnt] = config_in;
      shift_cnt++;
    end
    if (done) done_cnt++;
    if (word_ready && !word_valid) starve_cnt++;
    if (config_shift_b) begin
      if (shift_cnt_b < 64) bits_b[shift_cnt_b] = config_in_b;
      shift_cnt_b++;
    end
    if (done_b) done_cnt_b++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input bit to_b);
    if (to_b) start_b = 1'b1;
    else      start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send_word(input bit to_b, input logic [31:0] d, input int pre_gap);
    bit hs = 0;
    tick(pre_gap);
    word_valid = 1'b1;
    word_data  = d;
    for (int c = 0; c < 400 && !hs; c++) begin
      @(posedge clk);
      hs = to_b ? word_ready_b : word_ready;
      #1;
    end
    word_valid = 1'b0;
    word_data  = $urandom;
    if (!hs) check("word_accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input bit to_b);
    int c = 0;
    while ((to_b ? done_cnt_b : done_cnt) == 0 && c < 500) begin
      tick(1);
      c++;
    end
    if (c >= 500) check("done_timeout", 0, 1);
    tick(3);
  endtask

  logic [31:0] words[3];

  task automatic load_a(input int gap1, input bit mid_start);
    logic [CHAIN_LEN-1:0] exp_chain;
    shift_cnt = 0; done_cnt = 0; starve_cnt = 0;
    pulse_start(0);
    send_word(0, words[0], 0);
    if (mid_start) begin
      tick(5);
      pulse_start(0);
    end
    send_word(0, words[1], gap1);
    send_word(0, words[2], 0);
    wait_done(0);
    // Stream bit i ends up i cells short of the tail.
    for (int i = 0; i < CHAIN_LEN; i++) exp_chain[CHAIN_LEN-1-i] = words[i / WORD_W][i % WORD_W];
    check("shift_count", shift_cnt, CHAIN_LEN);
    check("done_count", done_cnt, 1);
    check("chain_contents", chain_q, exp_chain);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  tail8;
    logic [31:0] head32;
    int c;

    // Reset state.
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_word_ready", word_ready, 0);
    check("rst_config_in", config_in, 0);
    check("rst_config_shift", config_shift, 0);
    check("rst_echo_err", echo_err, 0);
    check("rst_config_reset", config_reset, 1);
    checking = 1;
    reset = 1'b0;
    #2;
    check("rst_config_reset_held", config_reset, 1);
    @(posedge clk); #1;
    check("rst_config_reset_release", config_reset, 0);
    tick(2);

    // Nominal load.
    words = '{32'h0000_0001, 32'h0000_0000, 32'h8000_0000};
    load_a(0, 0);
    check("nominal_first_bit", bits_a[0], 1);
    check("nominal_mid_bit", bits_a[47], 0);
    check("nominal_last_bit", bits_a[95], 1);
    check("nominal_echo_err", echo_err, 0);

    // Starvation: 52 cycles after word 0 (32 shifting + 20 stalled).
    words = '{$urandom, $urandom, $urandom};
    load_a(52, 0);
    check("starve_cycles", starve_cnt, 20);

    // Echo fault, then the next start clears it.
    force_one = 1'b1;
    words = '{$urandom, $urandom, $urandom};
    load_a(0, 0);
    check("echo_fault_set", echo_err, 1);
    force_one = 1'b0;
    shift_cnt = 0; done_cnt = 0;
    pulse_start(0);
    tick(1);
    check("echo_cleared_by_start", echo_err, 0);
    send_word(0, $urandom, 0);
    send_word(0, $urandom, 0);
    send_word(0, $urandom, 0);
    wait_done(0);
    check("echo_clean_shift_count", shift_cnt, CHAIN_LEN);

    // start during SHIFT is ignored.
    words = '{$urandom, $urandom, $urandom};
    load_a(0, 1);

    // Reset in the middle of SHIFT at bit 50.
    shift_cnt = 0; done_cnt = 0;
    pulse_start(0);
    send_word(0, $urandom, 0);
    send_word(0, $urandom, 0);
    c = 0;
    while (shift_cnt < 50 && c < 200) begin tick(1); c++; end
    if (c >= 200) check("reach_bit50_timeout", 0, 1);
    check("pre_reset_shift", config_shift, 1);
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_config_shift", config_shift, 0);
    check("midrst_config_reset", config_reset, 1);
    check("midrst_word_ready", word_ready, 0);
    check("midrst_done", done, 0);
    check("midrst_config_in", config_in, 0);
    tick(2);
    reset = 1'b0;
    tick(10);
    check("midrst_no_more_shifts", shift_cnt, 50);
    check("midrst_no_done", done_cnt, 0);

    // Partial final word on the 40-bit chain.
    shift_cnt_b = 0; done_cnt_b = 0;
    pulse_start(1);
    send_word(1, 32'hFFFF_FFFF, 0);
    send_word(1, 32'hFFFF_FF01, 0);
    wait_done(1);
    for (int i = 0; i < 8; i++)  tail8[i]  = bits_b[32 + i];
    for (int i = 0; i < 32; i++) head32[i] = bits_b[i];
    check("partial_shift_count", shift_cnt_b, CHAIN_B);
    check("partial_done_count", done_cnt_b, 1);
    check("partial_tail_bits", tail8, 8'h01);
    check("partial_head_bits", head32, 32'hFFFF_FFFF);
    check("partial_echo_err", echo_err_b, 0);

    // Randomised loads.
    for (int n = 0; n < 8; n++) begin
      words = '{$urandom, $urandom, $urandom};
      force_one = ($urandom_range(0, 3) == 0);
      load_a($urandom_range(0, 45), $urandom_range(0, 1) == 1);
      force_one = 1'b0;
      tick($urandom_range(0, 4));
    end

    checking = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

Interface
REQ-001 Parameter WORD_W, default 32, width of each host bitstream word.
REQ-002 Parameter CHAIN_LEN, default 96, total number of config bits in the target serial chain.
REQ-003 Parameter RST_CYCLES, default 4, number of cycles config_reset is held at the start of a load.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port start, input, 1: one-cycle load request.
REQ-007 Port busy, output, 1: high from the cycle after an accepted start until done.
REQ-008 Port done, output, 1: one-cycle pulse when the last chain bit has been shifted.
REQ-009 Port word_valid, input, 1: host bitstream word available.
REQ-010 Port word_ready, output, 1: loader accepts the word this cycle.
REQ-011 Port word_data, input, WORD_W: bitstream word; bit 0 is shifted first.
REQ-012 Port config_reset, output, 1: reset to every config_cell in the chain.
REQ-013 Port config_in, output, 1: serial data driven into the head of the chain.
REQ-014 Port config_shift, output, 1: clock-enable qualifying one chain shift per asserted cycle.
REQ-015 Port config_out, input, 1: tail of the chain; used for the first-bit echo check.
REQ-016 Port echo_err, output, 1: sticky flag set when the echo check fails; cleared by start.

Function
REQ-017 The FSM SHALL have states IDLE, CHAIN_RST, FETCH, SHIFT, DONE.
REQ-018 In IDLE, start=1 SHALL move the FSM to CHAIN_RST, clear echo_err and zero the bit counter; start in any other state SHALL be ignored.
REQ-019 CHAIN_RST SHALL hold config_reset=1 for exactly RST_CYCLES cycles, then go to FETCH.
REQ-020 In FETCH, word_ready SHALL be 1; on word_valid&word_ready the word SHALL load into the shift register and the FSM SHALL go to SHIFT.
REQ-021 In SHIFT, each cycle SHALL drive config_in=shreg[0], assert config_shift, shift shreg right by one and increment the bit counter.
REQ-022 After WORD_W shifts, or when the bit counter reaches CHAIN_LEN, SHIFT SHALL exit: to FETCH if bits remain, else to DONE.
REQ-023 The unused high bits of the final word (CHAIN_LEN mod WORD_W nonzero) SHALL be discarded and never shifted.
REQ-024 config_shift SHALL be asserted for exactly CHAIN_LEN cycles per load.
REQ-025 Host starvation (word_valid=0 in FETCH) SHALL stall with config_shift=0 and no timeout.
REQ-026 Echo check: on the shift at which the bit counter equals CHAIN_LEN-1, config_out SHALL equal 0 (chain fully reset); a mismatch SHALL set echo_err.
REQ-027 DONE SHALL last one cycle, pulse done=1, then return to IDLE.
REQ-028 busy SHALL be 1 in CHAIN_RST, FETCH, SHIFT and DONE.
REQ-029 word_ready SHALL be 0 in every state except FETCH.

Reset
REQ-030 On reset=1, the FSM SHALL go to IDLE, and busy, done, word_ready, config_in, config_shift and echo_err SHALL be 0.
REQ-031 On reset=1, config_reset SHALL be 1 and SHALL stay 1 until the first clock edge after reset deassertion.
REQ-032 A reset during any state SHALL abort the load with no further config_shift; the chain contents are then undefined until the next start.

Structure
REQ-033 A shared package cfg_loader_pkg SHALL hold the FSM state enum and the localparams NUM_WORDS=ceil(CHAIN_LEN/WORD_W) and CNT_W=$clog2(CHAIN_LEN+1).
REQ-034 The design SHALL be a single module with no sub-modules; the counter, shift register and FSM are all inline.

Verification
REQ-035 Nominal load: WORD_W=32, CHAIN_LEN=96, three words 0x1, 0x0, 0x80000000 -> config_in=1 at shift 0 and at shift 95, 96 config_shift cycles, done pulse, echo_err=0.
REQ-036 Partial word: CHAIN_LEN=40, words 0xFFFFFFFF and 0xFFFFFF01 -> exactly 40 shifts; config_in at shifts 32..39 equals 1,0,0,0,0,0,0,0.
REQ-037 Starvation: word_valid held low for 20 cycles before the second word -> config_shift=0 throughout the gap, total shifts still 96, busy stays high.
REQ-038 Echo fault: tie config_out=1 -> echo_err=1 after done; the next start clears it.
REQ-039 Reset mid-SHIFT at bit 50 -> outputs at reset values in the same cycle, config_reset=1, and no further shifts occur.
REQ-040 start pulsed during SHIFT -> ignored; exactly one done pulse and 96 shifts.
